// File: rtl/alu_cmd_sequencer.sv
// Initiator for the ALU operation port: buffers host commands, issues one at a time,
// captures the ALU result and returns it over a valid/ready response channel.
module alu_cmd_sequencer #(
    parameter int unsigned CMD_DEPTH = 4,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [3:0]           cmd_op_i,
    input  logic [31:0]          cmd_p_i,
    input  logic [31:0]          cmd_q_i,
    output logic [3:0]           alu_op_o,
    output logic [31:0]          alu_p_o,
    output logic [31:0]          alu_q_o,
    input  logic [31:0]          alu_result_i,
    input  logic [1:0]           alu_error_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [3:0]           rsp_op_o,
    output logic [31:0]          rsp_result_o,
    output logic [1:0]           rsp_error_o,
    output logic [1:0]           err_sticky_o,
    output logic [ERR_CNT_W-1:0] err_count_o,
    input  logic                 err_clear_i,
    output logic                 busy_o
);

    localparam int unsigned AW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam logic [3:0] OpReset    = 4'b1100;
    localparam logic [3:0] OpFeedback = 4'b1110;

    typedef enum logic [1:0] {StInit, StIdle, StIssue, StResp} state_e;

    state_e state_q, state_d;

    logic [3:0]  fifo_op_q [CMD_DEPTH];
    logic [31:0] fifo_p_q  [CMD_DEPTH];
    logic [31:0] fifo_q_q  [CMD_DEPTH];

    // Extra MSB on each pointer separates full from empty.
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic        fifo_empty, fifo_full, push, pop, capture;

    logic [3:0]           alu_op_q, alu_op_d;
    logic [31:0]          alu_p_q, alu_p_d, alu_q_q, alu_q_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [3:0]           rsp_op_q, rsp_op_d;
    logic [31:0]          rsp_result_q, rsp_result_d;
    logic [1:0]           rsp_error_q, rsp_error_d;
    logic [1:0]           err_sticky_q, err_sticky_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign cmd_ready_o = !fifo_full && (state_q != StInit);
    assign push        = cmd_valid_i && cmd_ready_o;

    always_comb begin
        state_d      = state_q;
        alu_op_d     = alu_op_q;
        alu_p_d      = alu_p_q;
        alu_q_d      = alu_q_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_op_d     = rsp_op_q;
        rsp_result_d = rsp_result_q;
        rsp_error_d  = rsp_error_q;
        err_sticky_d = err_sticky_q;
        err_count_d  = err_count_q;
        pop          = 1'b0;
        capture      = 1'b0;

        unique case (state_q)
            StInit: begin
                alu_op_d = OpFeedback;
                state_d  = StIdle;
            end
            StIdle: begin
                alu_op_d = OpFeedback;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                capture      = 1'b1;
                rsp_valid_d  = 1'b1;
                rsp_op_d     = alu_op_q;
                rsp_result_d = alu_result_i;
                rsp_error_d  = alu_error_i;
                alu_op_d     = OpFeedback;
                state_d      = StResp;
            end
            StResp: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = StIssue;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StInit;
        endcase

        if (pop) begin
            alu_op_d = fifo_op_q[rd_ptr_q[AW-1:0]];
            alu_p_d  = fifo_p_q[rd_ptr_q[AW-1:0]];
            alu_q_d  = fifo_q_q[rd_ptr_q[AW-1:0]];
        end

        // A clear on the capture edge discards that capture's error.
        if (err_clear_i) begin
            err_sticky_d = 2'b00;
            err_count_d  = '0;
        end else if (capture) begin
            err_sticky_d = err_sticky_q | alu_error_i;
            if (alu_error_i != 2'b00 && err_count_q != {ERR_CNT_W{1'b1}}) begin
                err_count_d = err_count_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_op_q[wr_ptr_q[AW-1:0]] <= cmd_op_i;
            fifo_p_q[wr_ptr_q[AW-1:0]]  <= cmd_p_i;
            fifo_q_q[wr_ptr_q[AW-1:0]]  <= cmd_q_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StInit;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            alu_op_q     <= OpReset;
            alu_p_q      <= '0;
            alu_q_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_op_q     <= '0;
            rsp_result_q <= '0;
            rsp_error_q  <= '0;
            err_sticky_q <= '0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            alu_op_q     <= alu_op_d;
            alu_p_q      <= alu_p_d;
            alu_q_q      <= alu_q_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_op_q     <= rsp_op_d;
            rsp_result_q <= rsp_result_d;
            rsp_error_q  <= rsp_error_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
        end
    end

    assign alu_op_o     = alu_op_q;
    assign alu_p_o      = alu_p_q;
    assign alu_q_o      = alu_q_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_op_o     = rsp_op_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_error_o  = rsp_error_q;
    assign err_sticky_o = err_sticky_q;
    assign err_count_o  = err_count_q;
    assign busy_o       = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: ALU stub (result = p + q + op, error = q[31:30]) and a
// queue-based reference model of command order, response contents and error statistics.
module tb_alu_cmd_sequencer;

    localparam int unsigned Depth = 4;
    localparam int unsigned ErrW  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic cmd_valid = 1'b0, cmd_ready;
    logic [3:0] cmd_op = '0;
    logic [31:0] cmd_p = '0, cmd_q = '0;
    logic [3:0] alu_op;
    logic [31:0] alu_p, alu_q, alu_result;
    logic [1:0] alu_error;
    logic rsp_valid, rsp_ready = 1'b0;
    logic [3:0] rsp_op;
    logic [31:0] rsp_result;
    logic [1:0] rsp_error, err_sticky;
    logic [ErrW-1:0] err_count;
    logic err_clear = 1'b0;
    logic busy;

    int vecs = 0;
    int errs = 0;
    int cyc = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] p;
        logic [31:0] q;
    } cmd_t;

    cmd_t exp_q[$];
    int m_count;
    logic [1:0] m_sticky;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign alu_result = alu_p + alu_q + {28'd0, alu_op};
    assign alu_error  = alu_q[31:30];

    alu_cmd_sequencer #(.CMD_DEPTH(Depth), .ERR_CNT_W(ErrW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_op_i(cmd_op), .cmd_p_i(cmd_p), .cmd_q_i(cmd_q),
        .alu_op_o(alu_op), .alu_p_o(alu_p), .alu_q_o(alu_q),
        .alu_result_i(alu_result), .alu_error_i(alu_error),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_op_o(rsp_op), .rsp_result_o(rsp_result), .rsp_error_o(rsp_error),
        .err_sticky_o(err_sticky), .err_count_o(err_count), .err_clear_i(err_clear),
        .busy_o(busy)
    );

    function automatic logic [31:0] ref_result(input cmd_t c);
        return c.p + c.q + 32'(c.op);
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [31:0] p, input logic [31:0] q);
        cmd_t c;
        int k = 0;
        c.op = op; c.p = p; c.q = q;
        cmd_valid = 1'b1; cmd_op = op; cmd_p = p; cmd_q = q;
        while (!cmd_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!cmd_ready) begin
            vecs++; errs++;
            $display("FAIL send_timeout got cmd_ready=%b exp=1", cmd_ready);
            cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        exp_q.push_back(c);
    endtask

    task automatic run_one(input logic [3:0] op, input logic [31:0] p, input logic [31:0] q,
                           output logic ok);
        int k = 0;
        rsp_ready = 1'b1;
        send(op, p, q);
        while (!rsp_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        ok = rsp_valid;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vecs++;
        if ({alu_op, alu_p, alu_q, cmd_ready, rsp_valid} !== {4'b1100, 64'd0, 2'b00}) begin
            errs++;
            $display("FAIL reset_alu got op=%b p=%h q=%h rdy=%b vld=%b exp op=1100 p=0 q=0 rdy=0 vld=0",
                     alu_op, alu_p, alu_q, cmd_ready, rsp_valid);
        end
        repeat (2) @(negedge clk);
        vecs++;
        if ({rsp_op, rsp_result, rsp_error, err_sticky, err_count} !== '0) begin
            errs++;
            $display("FAIL reset_rsp got op=%h res=%h err=%b sticky=%b cnt=%0d exp all zero",
                     rsp_op, rsp_result, rsp_error, err_sticky, err_count);
        end
        rst_n = 1'b1;
        #1;
        vecs++;
        if (alu_op !== 4'b1100 || cmd_ready !== 1'b0) begin
            errs++;
            $display("FAIL init_cycle got op=%b rdy=%b exp op=1100 rdy=0", alu_op, cmd_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vecs++;
            if (alu_op !== 4'b1110 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
                errs++;
                $display("FAIL idle_%0d got op=%b rdy=%b busy=%b exp op=1110 rdy=1 busy=0",
                         i, alu_op, cmd_ready, busy);
            end
        end
    endtask

    task automatic test_single();
        cmd_t c;
        rsp_ready = 1'b0;
        send(4'b0000, 32'd5, 32'd7);
        c = exp_q.pop_front();
        vecs++;
        if (rsp_valid !== 1'b0 || alu_op !== 4'b1110) begin
            errs++;
            $display("FAIL single_accept got vld=%b op=%b exp vld=0 op=1110", rsp_valid, alu_op);
        end
        @(negedge clk);
        vecs++;
        if (alu_op !== 4'b0000 || alu_p !== 32'd5 || alu_q !== 32'd7 || rsp_valid !== 1'b0) begin
            errs++;
            $display("FAIL single_issue got op=%b p=%0d q=%0d vld=%b exp op=0000 p=5 q=7 vld=0",
                     alu_op, alu_p, alu_q, rsp_valid);
        end
        @(negedge clk);
        vecs++;
        if (rsp_valid !== 1'b1 || rsp_result !== ref_result(c) || rsp_op !== c.op ||
            rsp_error !== 2'b00 || alu_op !== 4'b1110) begin
            errs++;
            $display("FAIL single_rsp got vld=%b res=%0d op=%b err=%b aluop=%b exp 1 %0d 0000 00 1110",
                     rsp_valid, rsp_result, rsp_op, rsp_error, alu_op, ref_result(c));
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vecs++;
            if (rsp_valid !== 1'b1 || rsp_result !== 32'd12 || rsp_op !== 4'b0000) begin
                errs++;
                $display("FAIL single_hold_%0d got vld=%b res=%0d op=%b exp 1 12 0000",
                         i, rsp_valid, rsp_result, rsp_op);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        vecs++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || alu_p !== 32'd5) begin
            errs++;
            $display("FAIL single_done got vld=%b busy=%b p=%0d exp vld=0 busy=0 p=5",
                     rsp_valid, busy, alu_p);
        end
    endtask

    task automatic test_back_to_back();
        cmd_t c;
        int k, last;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(4'(i + 1), $urandom, {2'b00, 30'($urandom)});
            if (i == 3) begin
                vecs++;
                if (cmd_ready !== 1'b1) begin
                    errs++;
                    $display("FAIL fill_room got rdy=%b exp=1", cmd_ready);
                end
            end
        end
        vecs++;
        if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1) begin
            errs++;
            $display("FAIL fill_full got rdy=%b vld=%b exp rdy=0 vld=1", cmd_ready, rsp_valid);
        end
        rsp_ready = 1'b1;
        last = 0;
        for (int i = 0; i < 5; i++) begin
            k = 0;
            while (!rsp_valid && k < 20) begin
                @(negedge clk);
                k++;
            end
            c = exp_q.pop_front();
            vecs++;
            if (rsp_valid !== 1'b1 || rsp_op !== c.op || rsp_result !== ref_result(c)) begin
                errs++;
                $display("FAIL b2b_rsp_%0d got vld=%b op=%h res=%h exp 1 %h %h",
                         i, rsp_valid, rsp_op, rsp_result, c.op, ref_result(c));
            end
            if (i > 0) begin
                vecs++;
                if (cyc - last != 2) begin
                    errs++;
                    $display("FAIL b2b_gap_%0d got %0d cycles exp 2", i, cyc - last);
                end
            end
            last = cyc;
            @(negedge clk);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_errors();
        cmd_t c;
        logic ok;
        int k = 0;
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        run_one(4'b0011, 32'd100, {2'b01, 30'd4}, ok);
        c = exp_q.pop_front();
        vecs++;
        if (!ok || rsp_error !== 2'b01 || rsp_result !== ref_result(c) || err_sticky !== 2'b01 ||
            err_count !== 8'd1) begin
            errs++;
            $display("FAIL err_first got ok=%b err=%b res=%h sticky=%b cnt=%0d exp 1 01 %h 01 1",
                     ok, rsp_error, rsp_result, err_sticky, err_count, ref_result(c));
        end
        run_one(4'b0011, 32'd9, {2'b10, 30'd3}, ok);
        void'(exp_q.pop_front());
        vecs++;
        if (!ok || rsp_error !== 2'b10 || err_sticky !== 2'b11 || err_count !== 8'd2) begin
            errs++;
            $display("FAIL err_second got ok=%b err=%b sticky=%b cnt=%0d exp 1 10 11 2",
                     ok, rsp_error, err_sticky, err_count);
        end
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        vecs++;
        if (err_sticky !== 2'b00 || err_count !== 8'd0) begin
            errs++;
            $display("FAIL err_clear got sticky=%b cnt=%0d exp 00 0", err_sticky, err_count);
        end
        // Hold clear across the capture edge; the capture must not count.
        err_clear = 1'b1;
        rsp_ready = 1'b0;
        send(4'b0011, 32'd1, {2'b11, 30'd1});
        void'(exp_q.pop_front());
        while (!rsp_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        vecs++;
        if (rsp_valid !== 1'b1 || err_count !== 8'd0 || err_sticky !== 2'b00) begin
            errs++;
            $display("FAIL err_clear_wins got vld=%b cnt=%0d sticky=%b exp 1 0 00",
                     rsp_valid, err_count, err_sticky);
        end
        err_clear = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        run_one(4'b0011, 32'd1, {2'b11, 30'd1}, ok);
        void'(exp_q.pop_front());
        vecs++;
        if (err_count !== 8'd1 || err_sticky !== 2'b11) begin
            errs++;
            $display("FAIL err_code3 got cnt=%0d sticky=%b exp 1 11", err_count, err_sticky);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_saturate();
        int k;
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        rsp_ready = 1'b1;
        m_count = 0;
        for (int i = 0; i < 300; i++) begin
            send($urandom, $urandom, {2'((i % 3) + 1), 30'($urandom)});
            m_count = (m_count < 255) ? m_count + 1 : 255;
            if (i == 199 || i == 299) begin
                k = 0;
                while (busy && k < 100) begin
                    @(negedge clk);
                    k++;
                end
                vecs++;
                if (busy !== 1'b0 || err_count !== ErrW'(m_count) || err_sticky !== 2'b11) begin
                    errs++;
                    $display("FAIL sat_%0d got busy=%b cnt=%0d sticky=%b exp 0 %0d 11",
                             i + 1, busy, err_count, err_sticky, m_count);
                end
            end
        end
        exp_q.delete();
        rsp_ready = 1'b0;
    endtask

    task automatic test_random();
        int n = 60;
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        m_count = 0;
        m_sticky = 2'b00;
        exp_q.delete();
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    send($urandom, $urandom, $urandom);
                end
            end
            begin
                int got = 0;
                int guard = 0;
                logic pend = 1'b0;
                logic [38:0] held = '0;
                cmd_t c;
                while (got < n && guard < 5000) begin
                    @(negedge clk);
                    guard++;
                    if (pend) begin
                        vecs++;
                        if ({rsp_valid, rsp_op, rsp_result, rsp_error} !== held) begin
                            errs++;
                            $display("FAIL rnd_hold got %h exp %h",
                                     {rsp_valid, rsp_op, rsp_result, rsp_error}, held);
                        end
                    end
                    rsp_ready = 1'($urandom_range(0, 1));
                    pend = rsp_valid && !rsp_ready;
                    held = {rsp_valid, rsp_op, rsp_result, rsp_error};
                    if (rsp_valid && rsp_ready) begin
                        vecs++;
                        if (exp_q.size() == 0) begin
                            errs++;
                            $display("FAIL rnd_extra got op=%h res=%h exp no response",
                                     rsp_op, rsp_result);
                        end else begin
                            c = exp_q.pop_front();
                            if (rsp_op !== c.op || rsp_result !== ref_result(c) ||
                                rsp_error !== c.q[31:30]) begin
                                errs++;
                                $display("FAIL rnd_rsp_%0d got %h/%h/%b exp %h/%h/%b", got,
                                         rsp_op, rsp_result, rsp_error,
                                         c.op, ref_result(c), c.q[31:30]);
                            end
                            m_sticky = m_sticky | c.q[31:30];
                            if (c.q[31:30] != 2'b00 && m_count < 255) m_count++;
                        end
                        got++;
                    end
                end
                vecs++;
                if (got != n) begin
                    errs++;
                    $display("FAIL rnd_timeout got %0d responses exp %0d", got, n);
                end
            end
        join
        @(negedge clk);
        rsp_ready = 1'b0;
        vecs++;
        if (err_count !== ErrW'(m_count) || err_sticky !== m_sticky || exp_q.size() != 0) begin
            errs++;
            $display("FAIL rnd_errstat got cnt=%0d sticky=%b left=%0d exp %0d %b 0",
                     err_count, err_sticky, exp_q.size(), m_count, m_sticky);
        end
    endtask

    task automatic test_reset_mid();
        int stale = 0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(4'(i + 2), $urandom, $urandom);
        exp_q.delete();
        vecs++;
        if (alu_op !== 4'd3) begin
            errs++;
            $display("FAIL mid_issue got op=%h exp 3", alu_op);
        end
        rst_n = 1'b0;
        #1;
        vecs++;
        if ({alu_op, alu_p, alu_q, rsp_valid, cmd_ready, rsp_result, rsp_op} !==
            {4'b1100, 64'd0, 2'b00, 36'd0}) begin
            errs++;
            $display("FAIL mid_reset got op=%b p=%h q=%h vld=%b rdy=%b res=%h exp 1100 0 0 0 0 0",
                     alu_op, alu_p, alu_q, rsp_valid, cmd_ready, rsp_result);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        vecs++;
        if (alu_op !== 4'b1100) begin
            errs++;
            $display("FAIL mid_init got op=%b exp 1100", alu_op);
        end
        @(negedge clk);
        vecs++;
        if (alu_op !== 4'b1110 || cmd_ready !== 1'b1) begin
            errs++;
            $display("FAIL mid_idle got op=%b rdy=%b exp 1110 1", alu_op, cmd_ready);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid || busy || alu_op != 4'b1110) stale++;
        end
        vecs++;
        if (stale != 0) begin
            errs++;
            $display("FAIL mid_stale got %0d active cycles exp 0", stale);
        end
        rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_errors();
        test_saturate();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
